// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus arbiter slice.
package mips_bus_pkg;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;

  typedef enum logic {FETCH, DATA} requester_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_timeout.sv
// Waitrequest watchdog: counts consecutive stalled granted cycles and pulses
// expire_o in the cycle the limit is reached.
module mips_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expire_o = enable_i && (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style bus between instruction fetch
// and data accesses, with a waitrequest watchdog and sticky bus_error.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        bus_error
);

  arb_state_t state_q, state_d, cur_state;
  requester_t last_served_q, last_served_d;
  logic       bus_error_q, bus_error_d;
  logic       d_req, grant_req, stall_en, expire;

  // Outputs look idle while reset is held, even before the reset edge lands.
  assign cur_state = reset ? IDLE : state_q;
  assign d_req     = d_read || d_write;
  assign grant_req = ((cur_state == GNT_I) && i_read) || ((cur_state == GNT_D) && d_req);
  assign stall_en  = grant_req && m_waitrequest;
  assign bus_error = bus_error_q;

  mips_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable_i(stall_en),
    .clear_i (!stall_en),
    .expire_o(expire)
  );

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    bus_error_d   = bus_error_q || expire;
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_byteenable  = '0;
    m_writedata   = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    unique case (cur_state)
      IDLE: begin
        if (i_read && d_req) begin
          state_d = (last_served_q == FETCH) ? GNT_D : GNT_I;
        end else if (i_read) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        m_address    = i_address;
        m_read       = i_read;
        m_byteenable = BE_WORD;
        // A withdrawn request just releases the bus without completing.
        if (!i_read) begin
          state_d = IDLE;
        end else if (!m_waitrequest || expire) begin
          i_waitrequest = 1'b0;
          i_readdata    = expire ? 32'h0 : m_readdata;
          state_d       = IDLE;
          last_served_d = FETCH;
        end
      end
      GNT_D: begin
        m_address    = d_address;
        m_read       = d_read && !d_write;
        m_write      = d_write;
        m_byteenable = d_byteenable;
        m_writedata  = d_writedata;
        if (!d_req) begin
          state_d = IDLE;
        end else if (!m_waitrequest || expire) begin
          d_waitrequest = 1'b0;
          d_readdata    = expire ? 32'h0 : m_readdata;
          state_d       = IDLE;
          last_served_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= FETCH;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      bus_error_q   <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_mips_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_writedata = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        bus_error;

  int assertCount = 0;
  int failCount = 0;

  // Model: who holds the bus (0 none, 1 fetch, 2 data), who was served last,
  // how many stalled cycles the current holder has waited, and the error flag.
  int   owner = 0;
  int   lastSrv = 1;
  int   waits = 0;
  logic err = 1'b0;
  logic modelValid = 1'b0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_byteenable (d_byteenable),
    .d_writedata  (d_writedata),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest),
    .m_readdata   (m_readdata),
    .bus_error    (bus_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic iRd, input logic [31:0] iA,
                               input logic dRd, input logic dWr, input logic [31:0] dA,
                               input logic [3:0] be, input logic [31:0] wd,
                               input logic mw, input logic [31:0] mrd);
    @(negedge clk);
    reset         = rst;
    i_read        = iRd;
    i_address     = iA;
    d_read        = dRd;
    d_write       = dWr;
    d_address     = dA;
    d_byteenable  = be;
    d_writedata   = wd;
    m_waitrequest = mw;
    m_readdata    = mrd;
  endtask

  // Compare process: every cycle, derive expected outputs from the model,
  // compare, then advance the model to what the coming clock edge produces.
  initial begin : compareProc
    forever begin
      int          who;
      logic        req, finishOk, timedOut;
      logic [31:0] eAddr, eWd, eIrd, eDrd;
      logic        eRd, eWr, eIw, eDw;
      logic [3:0]  eBe;
      @(negedge clk);
      #2;
      who      = reset ? 0 : owner;
      req      = (who == 1) ? i_read : (who == 2) ? (d_read || d_write) : 1'b0;
      finishOk = req && !m_waitrequest;
      timedOut = req && m_waitrequest && (waits == TO - 1);
      eAddr = '0; eWd = '0; eIrd = '0; eDrd = '0;
      eRd = 1'b0; eWr = 1'b0; eIw = 1'b1; eDw = 1'b1; eBe = '0;
      if (who == 1) begin
        eAddr = i_address;
        eRd   = i_read;
        eBe   = 4'hF;
        if (finishOk || timedOut) begin
          eIw  = 1'b0;
          eIrd = finishOk ? m_readdata : 32'h0;
        end
      end else if (who == 2) begin
        eAddr = d_address;
        eRd   = d_read && !d_write;
        eWr   = d_write;
        eBe   = d_byteenable;
        eWd   = d_writedata;
        if (finishOk || timedOut) begin
          eDw  = 1'b0;
          eDrd = finishOk ? m_readdata : 32'h0;
        end
      end
      if (modelValid) begin
        checkOutput("m_address", m_address, eAddr);
        checkOutput("m_read", 32'(m_read), 32'(eRd));
        checkOutput("m_write", 32'(m_write), 32'(eWr));
        checkOutput("m_byteenable", 32'(m_byteenable), 32'(eBe));
        checkOutput("m_writedata", m_writedata, eWd);
        checkOutput("i_waitrequest", 32'(i_waitrequest), 32'(eIw));
        checkOutput("i_readdata", i_readdata, eIrd);
        checkOutput("d_waitrequest", 32'(d_waitrequest), 32'(eDw));
        checkOutput("d_readdata", d_readdata, eDrd);
        checkOutput("bus_error", 32'(bus_error), 32'(err));
      end
      if (reset) begin
        owner = 0; lastSrv = 1; waits = 0; err = 1'b0; modelValid = 1'b1;
      end else if (owner == 0) begin
        if (i_read && (d_read || d_write)) owner = (lastSrv == 1) ? 2 : 1;
        else if (i_read) owner = 1;
        else if (d_read || d_write) owner = 2;
      end else if (!req) begin
        owner = 0; waits = 0;
      end else if (finishOk || timedOut) begin
        if (timedOut) err = 1'b1;
        lastSrv = owner; owner = 0; waits = 0;
      end else begin
        waits++;
      end
    end
  end

  initial begin : stimulusProc
    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset_i_wait", 32'(i_waitrequest), 32'd1);
    checkOutput("reset_d_wait", 32'(d_waitrequest), 32'd1);
    checkOutput("reset_m_read", 32'(m_read), 32'd0);
    checkOutput("reset_bus_error", 32'(bus_error), 32'd0);

    // Single fetch: one arbitration cycle, completion on cycle 2, idle on 3
    applyStimulus(0, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h8C010004);
    #3;
    checkOutput("t1_arb_m_read", 32'(m_read), 32'd0);
    checkOutput("t1_arb_i_wait", 32'(i_waitrequest), 32'd1);
    applyStimulus(0, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h8C010004);
    #3;
    checkOutput("t1_m_read", 32'(m_read), 32'd1);
    checkOutput("t1_m_address", m_address, 32'hBFC00000);
    checkOutput("t1_i_wait", 32'(i_waitrequest), 32'd0);
    checkOutput("t1_i_readdata", i_readdata, 32'h8C010004);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8C010004);
    #3;
    checkOutput("t1_idle_m_read", 32'(m_read), 32'd0);
    checkOutput("t1_idle_i_wait", 32'(i_waitrequest), 32'd1);

    // Tie after reset: data first, then alternate D, I, D, I
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 1, 32'h00400000, 1, 0, 32'h10010000, 4'hF, 0, 0, 32'h12340000 + k);
      #3;
      if (k % 2 == 1) begin
        checkOutput("t2_arb_m_read", 32'(m_read), 32'd0);
      end else begin
        checkOutput("t2_grant_addr", m_address, (k % 4 == 2) ? 32'h10010000 : 32'h00400000);
      end
    end

    // Stalled store: three stall cycles then completion
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h8, 4'b0011, 32'h5C3A18FC, (c == 5) ? 1'b0 : 1'b1, 0);
      #3;
      if (c == 1) begin
        checkOutput("t3_arb_m_write", 32'(m_write), 32'd0);
      end else begin
        checkOutput("t3_m_write", 32'(m_write), 32'd1);
        checkOutput("t3_m_byteenable", 32'(m_byteenable), 32'h3);
        checkOutput("t3_m_writedata", m_writedata, 32'h5C3A18FC);
        checkOutput("t3_d_wait", 32'(d_waitrequest), (c == 5) ? 32'd0 : 32'd1);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Timeout on a fetch: abort on the 4th granted cycle, sticky error
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 1, 32'h00400010, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
      #3;
      checkOutput("t4_bus_error_before", 32'(bus_error), 32'd0);
      if (c == 5) begin
        checkOutput("t4_i_wait_abort", 32'(i_waitrequest), 32'd0);
        checkOutput("t4_i_readdata_abort", i_readdata, 32'h0);
      end else begin
        checkOutput("t4_i_wait_stall", 32'(i_waitrequest), 32'd1);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(0, c <= 2, 32'h00400020, 0, c > 2, 32'h30, 4'hF, 32'h1, 0, 32'h11);
      #3;
      checkOutput("t4_bus_error_sticky", 32'(bus_error), 32'd1);
    end

    // Reset during a stalled data write
    applyStimulus(0, 0, 0, 0, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 1, 0);
    #3;
    checkOutput("t5_m_write_granted", 32'(m_write), 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    checkOutput("t5_m_write_after", 32'(m_write), 32'd0);
    checkOutput("t5_d_wait_after", 32'(d_waitrequest), 32'd1);
    checkOutput("t5_bus_error_cleared", 32'(bus_error), 32'd0);
    applyStimulus(0, 1, 32'h00400040, 1, 0, 32'h10010040, 4'hF, 0, 0, 0);
    applyStimulus(0, 1, 32'h00400040, 1, 0, 32'h10010040, 4'hF, 0, 0, 0);
    #3;
    checkOutput("t5_tie_data_first", m_address, 32'h10010040);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous read and write is a write
    applyStimulus(0, 0, 0, 1, 1, 32'h40, 4'hF, 32'h77, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h40, 4'hF, 32'h77, 0, 0);
    #3;
    checkOutput("t6_m_write", 32'(m_write), 32'd1);
    checkOutput("t6_m_read", 32'(m_read), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom,
                    4'($urandom), $urandom,
                    $urandom_range(0, 3) != 0, $urandom);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of mips_cpu_bus between two requesters: instruction fetch (read-only) and data (load/store).
- Sits between the CPU core's fetch and memory stages and the external bus pins (address, read, write, waitrequest, byteenable, writedata, readdata).
- Round-robin arbitration with grant held until the transaction completes, plus a waitrequest timeout watchdog with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive cycles m_waitrequest may stay high while a transaction is granted before it is aborted.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_address  in  32  fetch byte address
- i_read  in  1  fetch read request, held until i_waitrequest low
- i_waitrequest  out  1  low for exactly the completing cycle of a fetch
- i_readdata  out  32  fetch data, valid when i_waitrequest low
- d_address  in  32  data byte address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_byteenable  in  4  data byte lanes
- d_writedata  in  32  store data
- d_waitrequest  out  1  low for exactly the completing cycle of a data access
- d_readdata  out  32  load data, valid when d_waitrequest low
- m_address  out  32  bus address
- m_read  out  1  bus read
- m_write  out  1  bus write
- m_byteenable  out  4  bus byte lanes (4'b1111 for fetch)
- m_writedata  out  32  bus store data
- m_waitrequest  in  1  bus stall
- m_readdata  in  32  bus read data, valid in the cycle m_waitrequest is low
- bus_error  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Registers: state, last_served (FETCH/DATA), timeout counter, bus_error.
- Reset values: state=IDLE, last_served=FETCH (data wins the first tie), counter=0, bus_error=0.
- Output values while in reset or IDLE: m_read=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, i_waitrequest=1, d_waitrequest=1, i_readdata=0, d_readdata=0.
- IDLE transitions:
  - Only i_read set: go to GNT_I.
  - Only (d_read|d_write) set: go to GNT_D.
  - Both set: grant the requester that is not last_served.
  - Neither set: stay in IDLE.
  - Arbitration costs exactly one cycle. Bus outputs are never driven in IDLE.
- GNT_I drive: m_address=i_address, m_read=i_read, m_write=0, m_byteenable=4'b1111.
- GNT_D drive: m_address=d_address, m_read=d_read & ~d_write, m_write=d_write, m_byteenable=d_byteenable, m_writedata=d_writedata. A simultaneous d_read and d_write is treated as a write.
- Completion: in GNT_x with m_waitrequest=0, drive x_waitrequest=0 combinationally and pass m_readdata to x_readdata. Next state is IDLE, last_served=x, counter cleared. Minimum access time is 2 cycles per transaction, including the arbitration cycle.
- The non-granted requester's waitrequest stays 1 throughout.
- Stall: in GNT_x with m_waitrequest=1, the counter increments each cycle.
- Timeout: if m_waitrequest=1 and counter==TIMEOUT_CYCLES-1, abort in that cycle:
  - drive x_waitrequest=0 with x_readdata=32'h0;
  - set bus_error;
  - next state IDLE, last_served=x, counter cleared.
- Request withdrawn while granted (protocol violation): bus strobes follow the requester and drop to 0. Next state is IDLE with no completion; last_served is unchanged.
- Back-to-back traffic: a requester re-asserting immediately after completion re-arbitrates in IDLE. Two continuous requesters therefore alternate I, D, I, D...
- Reset asserted mid-transaction: on the next edge the FSM returns to IDLE and every output takes its reset value. The aborted transaction gets no completion.
- No combinational path from i_*/d_* requests to x_waitrequest except through the registered state.

Decomposition:
- Shared package mips_bus_pkg:
  - typedef enum arb_state_t {IDLE, GNT_I, GNT_D};
  - typedef enum requester_t {FETCH, DATA};
  - constant BE_WORD = 4'b1111.
- One sub-module: mips_bus_timeout. It owns the counter, takes enable/clear, and emits the expire pulse. Everything else stays in mips_bus_arbiter.

Test Plan:
- Single fetch: i_read=1, i_address=32'hBFC00000, m_waitrequest=0, m_readdata=32'h8C010004. Required: m_read=1 on cycle 2, i_waitrequest=0 and i_readdata=32'h8C010004 on cycle 2, IDLE on cycle 3.
- Tie after reset: i_read and d_read both asserted. Required: GNT_D first (d_address on the bus), then GNT_I. With both held continuously, grants alternate D, I, D, I over 8 cycles.
- Stalled store: d_write=1, d_address=8, d_byteenable=4'b0011, d_writedata=32'h5C3A18FC, m_waitrequest=1 for 3 cycles. Required: m_write=1 with m_byteenable=4'b0011 held for 4 cycles; d_waitrequest low only on the 4th.
- Timeout: TIMEOUT_CYCLES=4, m_waitrequest stuck at 1 on a fetch. Required: i_waitrequest=0 and i_readdata=0 on the 4th granted cycle; bus_error=1 from then on, surviving later traffic until reset.
- Reset mid-access: assert reset during a stalled GNT_D. Required: next cycle m_write=0, d_waitrequest=1, bus_error=0, state IDLE; a subsequent tie grants DATA first.
- Simultaneous d_read and d_write: m_write=1, m_read=0.
